audio_quantizer: RTL and testbench
==================================

Name: audio_quantizer

Overview:
- Quantization stage between the MDCT and inverse-quantizer stages of the audio compression pipeline.
- Started and finished by the system process controller through its start_quan / finish_quan / rstn_quan handshake.
- Reads one frame of signed MDCT coefficients from the coefficient RAM and processes it band by band: finds each band's peak magnitude, derives a block-floating-point shift (scale factor), then writes rounded, saturated Q_W-bit coefficients plus one scale factor per band.

Parameters:
- COEF_W, 24, signed MDCT coefficient width
- Q_W, 8, signed quantized coefficient width
- N_COEF, 512, coefficients per frame
- BAND_LEN, 32, coefficients per band (power of 2, divides N_COEF)
- SF_W, 5, scale-factor width (must hold COEF_W-Q_W+1)

Ports:
- clk_in  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- rstn_quan  in  1  controller soft reset, synchronous active-low; low forces IDLE
- start_quan  in  1  start pulse, sampled on rising edge
- finish_quan  out  1  one-cycle done pulse
- coef_en  out  1  coefficient RAM read enable
- coef_addr  out  log2(N_COEF)  coefficient read address
- coef_rdata  in  COEF_W  signed read data, valid one cycle after coef_en
- q_we  out  1  quantized RAM write enable
- q_addr  out  log2(N_COEF)  quantized write address
- q_wdata  out  Q_W  signed quantized value
- sf_we  out  1  scale-factor RAM write enable
- sf_addr  out  log2(N_COEF/BAND_LEN)  band index
- sf_wdata  out  SF_W  shift for the band

Behaviour:
- Reset (rst_n low, async): all outputs 0, state IDLE, band counter 0, peak register 0.
- rstn_quan low: same values as reset, applied at the next rising edge. Valid mid-operation: aborts with no finish_quan pulse and no further writes.
- FSM states:
  - IDLE: wait for start_quan with rstn_quan high. Then go to SCAN, band=0. start_quan in any other state is ignored.
  - SCAN: BAND_LEN+1 cycles. Reads addr band*BAND_LEN+i for i=0..BAND_LEN-1. peak = max(peak, |coef_rdata|) on each returned word. Peak is unsigned COEF_W bits, so |-2^(COEF_W-1)| = 2^(COEF_W-1) is representable.
  - CALC: 1 cycle. s = smallest value in 0..COEF_W-Q_W+1 with (peak >> s) <= 2^(Q_W-1)-1. s is registered; peak cleared.
  - QUANT: BAND_LEN+2 cycles. Re-reads the same band.
    - Per word: q = (coef + (s>0 ? 2^(s-1) : 0)) >>> s, computed at COEF_W+1 bits.
    - Saturate q to ±(2^(Q_W-1)-1); the value -2^(Q_W-1) is never emitted.
    - q_we is registered: asserted two cycles after the matching coef_en, at the same address.
  - SFW: 1 cycle. sf_we=1, sf_addr=band, sf_wdata=s. If band is the last band go to DONE, else band+1 and go to SCAN.
  - DONE: finish_quan=1 for exactly this cycle, then IDLE.
- Latency: start sampled at edge 0 → finish_quan high NB*(2*BAND_LEN+5) cycles later, where NB=N_COEF/BAND_LEN. Defaults: 16*69 = 1104 cycles.
- Enables: coef_en, q_we and sf_we are never high outside SCAN/QUANT/SFW. q_we and sf_we are never high in the same cycle.
- Back-to-back frames: a new start in the cycle after DONE is accepted.

Decomposition:
- Shared package audio_pkg holds COEF_W, Q_W, N_COEF, BAND_LEN, SF_W and the state encoding constants. It is shared with the inverse quantizer, which uses the same s and frame geometry.
- One sub-module, quan_round_sat: purely combinational (coef, s) → saturated q. It is reused by the verification model and shared with the inverse-quantizer's checker.

Test Plan:
- Directed scenarios:
  - All-zero frame, start pulse → every sf_wdata=0, every q_wdata=0, 512 q writes, 16 sf writes, finish_quan at cycle 1104 after start.
  - Band 0 peak 127, coefs ±127 → s=0, q equals coef exactly.
  - Band 1 containing 1000, -1000, 3 → s=3; q = 125, -125, 0.
  - Band 2 containing 255 (peak) → s=1; q(255)=(256>>1)=128 saturates to 127; q(-255)=-127.
  - Band 3 containing -8388608 → s=17; q=-64; sf_wdata=17.
  - rstn_quan low for one cycle during band 5 QUANT → all enables drop the following cycle, no finish_quan; a fresh start then completes the full frame normally. A start_quan pulse mid-frame is ignored (finish timing unchanged).

Source files
------------

// File: rtl/audio_pkg.sv
// Shared geometry, state encoding and scale-factor helper for the quantizer / inverse quantizer.
// Latency: n/a (types, constants and a combinational function only).
// Backpressure: n/a.
package audio_pkg;

    localparam int COEF_W   = 24;   // signed MDCT coefficient width
    localparam int Q_W      = 8;    // signed quantized coefficient width
    localparam int N_COEF   = 512;  // coefficients per frame
    localparam int BAND_LEN = 32;   // coefficients per band
    localparam int SF_W     = 5;    // scale-factor width

    localparam int N_BAND = N_COEF / BAND_LEN;
    localparam int ADDR_W = $clog2(N_COEF);
    localparam int BAND_W = $clog2(N_BAND);
    localparam int OFS_W  = $clog2(BAND_LEN);
    localparam int CNT_W  = $clog2(BAND_LEN + 2);
    localparam int S_MAX  = COEF_W - Q_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_CALC  = 3'd2,
        ST_QUANT = 3'd3,
        ST_SFW   = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Smallest shift that brings the band peak into the positive Q_W range.
    // Scanning downward leaves the smallest qualifying shift in s.
    function automatic logic [SF_W-1:0] calc_shift(input logic [COEF_W-1:0] peak);
        logic [SF_W-1:0] s;
        s = SF_W'(S_MAX);
        for (int i = S_MAX; i >= 0; i--) begin
            if ((peak >> i) <= COEF_W'(2**(Q_W-1) - 1))
                s = SF_W'(i);
        end
        return s;
    endfunction

endpackage

// File: rtl/quan_round_sat.sv
// Round-half-up arithmetic shift of one coefficient, saturated to the symmetric Q_W range.
// Latency: combinational.
// Backpressure: none.
// Ports: coef (signed COEF_W in), s (shift in), q (signed Q_W out, never -2^(Q_W-1)).
module quan_round_sat
    import audio_pkg::*;
(
    input  logic [COEF_W-1:0] coef,
    input  logic [SF_W-1:0]   s,
    output logic [Q_W-1:0]    q
);

    localparam logic signed [COEF_W:0] Q_MAX = (COEF_W+1)'(2**(Q_W-1) - 1);
    localparam logic signed [COEF_W:0] Q_MIN = -Q_MAX;

    logic signed [COEF_W:0] ext;
    logic signed [COEF_W:0] rnd;
    logic signed [COEF_W:0] shf;

    // One extra bit of headroom so adding the rounding constant cannot wrap.
    always_comb begin
        ext = {coef[COEF_W-1], coef};
        rnd = '0;
        if (s != '0)
            rnd = (COEF_W+1)'(1) << (s - SF_W'(1));
        shf = (ext + rnd) >>> s;
        if (shf > Q_MAX)
            q = Q_MAX[Q_W-1:0];
        else if (shf < Q_MIN)
            q = Q_MIN[Q_W-1:0];
        else
            q = shf[Q_W-1:0];
    end

endmodule

// File: rtl/audio_quantizer.sv
// Band-by-band block-floating-point quantizer: peak scan, shift calc, round/saturate, write-back.
// Latency: finish_quan N_BAND*(2*BAND_LEN+5) cycles after the accepted start_quan edge.
// Backpressure: none; RAMs are assumed always ready, start_quan is ignored while busy.
// Ports: clk_in/rst_n (async), rstn_quan (sync soft reset), start_quan/finish_quan handshake,
//        coef_* read port (data one cycle after coef_en), q_* and sf_* write ports.
module audio_quantizer
    import audio_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              rstn_quan,
    input  logic              start_quan,
    output logic              finish_quan,
    output logic              coef_en,
    output logic [ADDR_W-1:0] coef_addr,
    input  logic [COEF_W-1:0] coef_rdata,
    output logic              q_we,
    output logic [ADDR_W-1:0] q_addr,
    output logic [Q_W-1:0]    q_wdata,
    output logic              sf_we,
    output logic [BAND_W-1:0] sf_addr,
    output logic [SF_W-1:0]   sf_wdata
);

    state_e              state_q, state_d;
    logic [BAND_W-1:0]   band_q, band_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [COEF_W-1:0]   peak_q, peak_d;
    logic [SF_W-1:0]     s_q, s_d;
    logic                rd_vld_q, rd_vld_d;     // coef_rdata holds a word this cycle
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;   // address of that word
    logic                q_we_q, q_we_d;
    logic [ADDR_W-1:0]   q_addr_q, q_addr_d;
    logic [Q_W-1:0]      q_wdata_q, q_wdata_d;

    logic [COEF_W-1:0]   coef_abs;
    logic [Q_W-1:0]      q_rs;

    quan_round_sat u_round_sat (
        .coef (coef_rdata),
        .s    (s_q),
        .q    (q_rs)
    );

    // Two's-complement negate in COEF_W bits maps the most negative value to
    // 2^(COEF_W-1), which is exactly right when read as unsigned.
    assign coef_abs = coef_rdata[COEF_W-1] ? (~coef_rdata + COEF_W'(1)) : coef_rdata;

    // State register
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            band_q    <= '0;
            cnt_q     <= '0;
            peak_q    <= '0;
            s_q       <= '0;
            rd_vld_q  <= 1'b0;
            rd_addr_q <= '0;
            q_we_q    <= 1'b0;
            q_addr_q  <= '0;
            q_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            band_q    <= band_d;
            cnt_q     <= cnt_d;
            peak_q    <= peak_d;
            s_q       <= s_d;
            rd_vld_q  <= rd_vld_d;
            rd_addr_q <= rd_addr_d;
            q_we_q    <= q_we_d;
            q_addr_q  <= q_addr_d;
            q_wdata_q <= q_wdata_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d   = state_q;
        band_d    = band_q;
        cnt_d     = cnt_q;
        peak_d    = peak_q;
        s_d       = s_q;
        rd_vld_d  = coef_en;
        rd_addr_d = coef_addr;
        q_we_d    = rd_vld_q && (state_q == ST_QUANT);
        q_addr_d  = q_we_d ? rd_addr_q : '0;
        q_wdata_d = q_we_d ? q_rs : '0;

        case (state_q)
            ST_IDLE: begin
                if (start_quan) begin
                    state_d = ST_SCAN;
                    band_d  = '0;
                    cnt_d   = '0;
                end
            end
            ST_SCAN: begin
                if (rd_vld_q && (coef_abs > peak_q))
                    peak_d = coef_abs;
                // One extra cycle so the last requested word is folded in.
                if (cnt_q == CNT_W'(BAND_LEN)) begin
                    state_d = ST_CALC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CALC: begin
                s_d     = calc_shift(peak_q);
                peak_d  = '0;
                state_d = ST_QUANT;
                cnt_d   = '0;
            end
            ST_QUANT: begin
                // Two extra cycles drain the read + output-register pipeline.
                if (cnt_q == CNT_W'(BAND_LEN + 1)) begin
                    state_d = ST_SFW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SFW: begin
                if (band_q == BAND_W'(N_BAND - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    band_d  = band_q + BAND_W'(1);
                    state_d = ST_SCAN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Controller soft reset overrides everything on the next edge.
        if (!rstn_quan) begin
            state_d   = ST_IDLE;
            band_d    = '0;
            cnt_d     = '0;
            peak_d    = '0;
            s_d       = '0;
            rd_vld_d  = 1'b0;
            rd_addr_d = '0;
            q_we_d    = 1'b0;
            q_addr_d  = '0;
            q_wdata_d = '0;
        end
    end

    // Outputs
    always_comb begin
        coef_en     = ((state_q == ST_SCAN) || (state_q == ST_QUANT)) && (cnt_q < CNT_W'(BAND_LEN));
        coef_addr   = coef_en ? {band_q, cnt_q[OFS_W-1:0]} : '0;
        sf_we       = (state_q == ST_SFW);
        sf_addr     = sf_we ? band_q : '0;
        sf_wdata    = sf_we ? s_q : '0;
        finish_quan = (state_q == ST_DONE);
        q_we        = q_we_q;
        q_addr      = q_addr_q;
        q_wdata     = q_wdata_q;
    end

endmodule

// File: tb/tb_audio_quantizer.sv
// Directed bench for audio_quantizer: behavioural coefficient RAM, write capture, immediate-assertion checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_audio_quantizer;
    import audio_pkg::*;

    logic              clk_in = 1'b0;
    logic              rst_n;
    logic              rstn_quan;
    logic              start_quan;
    logic              finish_quan;
    logic              coef_en;
    logic [ADDR_W-1:0] coef_addr;
    logic [COEF_W-1:0] coef_rdata;
    logic              q_we;
    logic [ADDR_W-1:0] q_addr;
    logic [Q_W-1:0]    q_wdata;
    logic              sf_we;
    logic [BAND_W-1:0] sf_addr;
    logic [SF_W-1:0]   sf_wdata;

    int checks = 0;
    int errors = 0;

    logic [COEF_W-1:0]     mem   [N_COEF];
    logic signed [Q_W-1:0] qmem  [N_COEF];
    logic [SF_W-1:0]       sfmem [N_BAND];
    int cyc = 0, q_cnt = 0, sf_cnt = 0, q_nz = 0, sf_nz = 0, fin_cnt = 0, ovl = 0;

    audio_quantizer dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .rstn_quan   (rstn_quan),
        .start_quan  (start_quan),
        .finish_quan (finish_quan),
        .coef_en     (coef_en),
        .coef_addr   (coef_addr),
        .coef_rdata  (coef_rdata),
        .q_we        (q_we),
        .q_addr      (q_addr),
        .q_wdata     (q_wdata),
        .sf_we       (sf_we),
        .sf_addr     (sf_addr),
        .sf_wdata    (sf_wdata)
    );

    always #5 clk_in = ~clk_in;

    // Coefficient RAM (one-cycle read) and write capture
    always @(posedge clk_in) begin
        cyc <= cyc + 1;
        if (coef_en) coef_rdata <= mem[coef_addr];
        if (q_we) begin
            qmem[q_addr] <= q_wdata;
            q_cnt <= q_cnt + 1;
            if (q_wdata != '0) q_nz <= q_nz + 1;
        end
        if (sf_we) begin
            sfmem[sf_addr] <= sf_wdata;
            sf_cnt <= sf_cnt + 1;
            if (sf_wdata != '0) sf_nz <= sf_nz + 1;
        end
        if (q_we && sf_we) ovl <= ovl + 1;
        if (finish_quan) fin_cnt <= fin_cnt + 1;
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Starts a frame and waits for finish_quan; optionally pulses start mid-frame.
    task automatic run_frame(input string tag, input int mid_start);
        int q0, s0, c0, lat;
        q0 = q_cnt;
        s0 = sf_cnt;
        @(negedge clk_in);
        start_quan = 1'b1;
        @(negedge clk_in);          // edge 0 has sampled start
        start_quan = 1'b0;
        c0  = cyc;
        lat = -1;
        for (int i = 0; i < 2000; i++) begin
            if (finish_quan) begin
                lat = cyc - c0;
                break;
            end
            start_quan = (i == mid_start);
            @(negedge clk_in);
        end
        start_quan = 1'b0;
        check({tag, "_latency"}, lat, 1104);
        @(negedge clk_in);
        check({tag, "_finish_one_cycle"}, finish_quan, 0);
        check({tag, "_q_writes"}, q_cnt - q0, N_COEF);
        check({tag, "_sf_writes"}, sf_cnt - s0, N_BAND);
    endtask

    initial begin
        int qnz0, snz0, f0, q0, s0;
        bit found;
        for (int i = 0; i < N_COEF; i++) mem[i] = '0;
        rst_n      = 1'b0;
        rstn_quan  = 1'b1;
        start_quan = 1'b0;
        repeat (2) @(negedge clk_in);

        // Reset state
        check("rst_finish", finish_quan, 0);
        check("rst_coef_en", coef_en, 0);
        check("rst_coef_addr", coef_addr, 0);
        check("rst_q_we", q_we, 0);
        check("rst_q_wdata", q_wdata, 0);
        check("rst_sf_we", sf_we, 0);
        check("rst_sf_wdata", sf_wdata, 0);
        rst_n = 1'b1;
        @(negedge clk_in);

        // All-zero frame
        qnz0 = q_nz;
        snz0 = sf_nz;
        run_frame("zero", -1);
        check("zero_q_nonzero", q_nz - qnz0, 0);
        check("zero_sf_nonzero", sf_nz - snz0, 0);

        // Directed data frame
        for (int i = 0; i < BAND_LEN; i++) mem[i] = (i % 2 == 1) ? -24'sd127 : 24'sd127;
        mem[32] = 24'sd1000;
        mem[33] = -24'sd1000;
        mem[34] = 24'sd3;
        mem[64] = 24'sd255;
        mem[65] = -24'sd255;
        mem[96] = -24'sd8388608;
        mem[97] = 24'sd100;
        run_frame("data", -1);
        check("b0_sf", sfmem[0], 0);
        check("b0_q_pos", qmem[0], 127);
        check("b0_q_neg", qmem[31], -127);
        check("b1_sf", sfmem[1], 3);
        check("b1_q_1000", qmem[32], 125);
        check("b1_q_m1000", qmem[33], -125);
        check("b1_q_3", qmem[34], 0);
        check("b2_sf", sfmem[2], 1);
        check("b2_q_sat_pos", qmem[64], 127);
        check("b2_q_m255", qmem[65], -127);
        check("b3_sf", sfmem[3], 17);
        check("b3_q_min", qmem[96], -64);
        check("b3_q_small", qmem[97], 0);
        check("b4_sf", sfmem[4], 0);
        check("b4_q", qmem[130], 0);

        // Abort with rstn_quan during band 5 QUANT
        @(negedge clk_in);
        start_quan = 1'b1;
        @(negedge clk_in);
        start_quan = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (q_we && (q_addr == ADDR_W'(170))) begin
                found = 1'b1;
                break;
            end
            @(negedge clk_in);
        end
        check("abort_reached_band5", found, 1);
        rstn_quan = 1'b0;
        @(negedge clk_in);
        rstn_quan = 1'b1;
        check("abort_coef_en", coef_en, 0);
        check("abort_q_we", q_we, 0);
        check("abort_sf_we", sf_we, 0);
        check("abort_finish", finish_quan, 0);
        f0 = fin_cnt;
        q0 = q_cnt;
        s0 = sf_cnt;
        repeat (1200) @(negedge clk_in);
        check("abort_no_finish", fin_cnt - f0, 0);
        check("abort_no_q_writes", q_cnt - q0, 0);
        check("abort_no_sf_writes", sf_cnt - s0, 0);

        // Fresh frame with an ignored mid-frame start pulse
        run_frame("restart", 300);
        check("restart_b1_sf", sfmem[1], 3);
        check("restart_b3_q", qmem[96], -64);

        check("no_q_sf_overlap", ovl, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
